// File: rtl/gfx_req_arbiter.sv
// Round-robin arbiter: three toggle-handshake background fetchers share one toggle-handshake SDRAM gfx port.
// Latency: pending -> mem_req toggle in 2 cycles; mem_ack match -> ack_x toggle on the next edge.
// Backpressure: one transaction outstanding; WAIT holds until mem_ack matches, and other requests stay pending.
module gfx_req_arbiter #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 32
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              req_c,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    output logic              ack_a,
    output logic              ack_b,
    output logic              ack_c,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] data_c,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_q,
    output logic [2:0]        grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rr_ptr;     // index of the requester the next search starts at
    logic [2:0]        pend;
    logic [2:0]        win;
    logic [ADDR_W-1:0] win_addr;
    logic              done;

    assign pend = {req_c ^ ack_c, req_b ^ ack_b, req_a ^ ack_a};
    assign done = (state == WAIT) && (mem_ack == mem_req);

    always_comb begin
        win = 3'b000;
        case (rr_ptr)
            2'd1: begin
                if (pend[1])      win = 3'b010;
                else if (pend[2]) win = 3'b100;
                else if (pend[0]) win = 3'b001;
            end
            2'd2: begin
                if (pend[2])      win = 3'b100;
                else if (pend[0]) win = 3'b001;
                else if (pend[1]) win = 3'b010;
            end
            default: begin
                if (pend[0])      win = 3'b001;
                else if (pend[1]) win = 3'b010;
                else if (pend[2]) win = 3'b100;
            end
        endcase
    end

    always_comb begin
        win_addr = addr_a;
        if (win[1]) win_addr = addr_b;
        if (win[2]) win_addr = addr_c;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pend) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mem_ack == mem_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Adopt the SDRAM's current ack phase so no transaction appears to be open.
            mem_req  <= mem_ack;
            mem_addr <= '0;
            grant    <= 3'b000;
            rr_ptr   <= 2'd0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            ack_c    <= 1'b0;
            data_a   <= '0;
            data_b   <= '0;
            data_c   <= '0;
        end else begin
            if (state == IDLE && |pend) begin
                grant    <= win;
                mem_addr <= win_addr;
            end
            if (state == ISSUE) mem_req <= ~mem_req;
            if (done) begin
                grant  <= 3'b000;
                rr_ptr <= grant[0] ? 2'd1 : (grant[1] ? 2'd2 : 2'd0);
                if (grant[0]) begin
                    data_a <= mem_q;
                    ack_a  <= req_a;
                end
                if (grant[1]) begin
                    data_b <= mem_q;
                    ack_b  <= req_b;
                end
                if (grant[2]) begin
                    data_c <= mem_q;
                    ack_c  <= req_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_gfx_req_arbiter.sv
// Directed bench for gfx_req_arbiter with a negedge-driven toggle-handshake SDRAM model.
module tb_gfx_req_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic [24:0] addr_a = '0, addr_b = '0, addr_c = '0;
    logic        ack_a, ack_b, ack_c;
    logic [31:0] data_a, data_b, data_c;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic        mem_ack = 1'b1;
    logic [31:0] mem_q   = '0;
    logic [2:0]  grant;

    // SDRAM model controls: answer after mem_wait mismatching negedges (2 = registered follower)
    int          mem_wait     = 2;
    bit          mem_hold     = 1'b1;
    bit          mem_fixed_en = 1'b0;
    logic [31:0] mem_fixed    = '0;
    int          mem_cnt      = 0;
    int          mreq_toggles = 0;

    int vec = 0;
    int err = 0;

    gfx_req_arbiter #(.ADDR_W(25), .DATA_W(32)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req_a   (req_a),
        .req_b   (req_b),
        .req_c   (req_c),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .addr_c  (addr_c),
        .ack_a   (ack_a),
        .ack_b   (ack_b),
        .ack_c   (ack_c),
        .data_a  (data_a),
        .data_b  (data_b),
        .data_c  (data_c),
        .mem_req (mem_req),
        .mem_addr(mem_addr),
        .mem_ack (mem_ack),
        .mem_q   (mem_q),
        .grant   (grant)
    );

    always #5 clk_sys = ~clk_sys;

    always @(mem_req) mreq_toggles++;

    always @(negedge clk_sys) begin
        if (!mem_hold && (mem_req != mem_ack)) begin
            mem_cnt++;
            if (mem_cnt >= mem_wait) begin
                mem_q   = mem_fixed_en ? mem_fixed : (32'hA000_0000 | {7'b0, mem_addr});
                mem_ack = mem_req;
                mem_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        req_c = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        do_reset();
        vec++; if (mem_req !== 1'b1) begin err++; $display("FAIL rst_mem_req got %b need 1", mem_req); end
        vec++; if (grant !== 3'b000) begin err++; $display("FAIL rst_grant got %b need 000", grant); end
        vec++; if ({ack_c, ack_b, ack_a} !== 3'b000) begin err++; $display("FAIL rst_acks got %b need 000", {ack_c, ack_b, ack_a}); end
        vec++; if (data_a !== 32'h0 || data_b !== 32'h0 || data_c !== 32'h0) begin
            err++; $display("FAIL rst_data got %h %h %h need 0", data_a, data_b, data_c);
        end
        vec++; if (mem_addr !== 25'h0) begin err++; $display("FAIL rst_mem_addr got %h need 0", mem_addr); end
        mem_hold = 1'b0;
        base = mreq_toggles;
        repeat (6) @(negedge clk_sys);
        vec++; if (mreq_toggles - base !== 0) begin err++; $display("FAIL rst_phantom got %0d toggles need 0", mreq_toggles - base); end
        vec++; if (grant !== 3'b000) begin err++; $display("FAIL rst_idle_grant got %b need 000", grant); end
    endtask

    task automatic test_single();
        int   cyc;
        int   base;
        logic req0;
        do_reset();
        mem_wait     = 5;
        mem_fixed_en = 1'b1;
        mem_fixed    = 32'hDEAD_BEEF;
        base = mreq_toggles;
        req0 = mem_req;
        addr_a = 25'h0012340;
        req_a  = 1'b1;
        @(negedge clk_sys);
        vec++; if (grant !== 3'b001) begin err++; $display("FAIL single_grant got %b need 001", grant); end
        vec++; if (mem_addr !== 25'h0012340) begin err++; $display("FAIL single_addr got %h need 0012340", mem_addr); end
        vec++; if (mem_req !== req0) begin err++; $display("FAIL single_early_toggle got %b need %b", mem_req, req0); end
        @(negedge clk_sys);
        vec++; if (mem_req !== ~req0) begin err++; $display("FAIL single_toggle got %b need %b", mem_req, ~req0); end
        cyc = 2;
        while (ack_a !== 1'b1 && cyc < 40) begin
            @(negedge clk_sys);
            cyc++;
        end
        vec++; if (cyc != 7) begin err++; $display("FAIL single_latency got %0d cycles need 7", cyc); end
        vec++; if (data_a !== 32'hDEAD_BEEF) begin err++; $display("FAIL single_data got %h need deadbeef", data_a); end
        vec++; if (grant !== 3'b000) begin err++; $display("FAIL single_grant_idle got %b need 000", grant); end
        vec++; if (mreq_toggles - base !== 1) begin err++; $display("FAIL single_toggles got %0d need 1", mreq_toggles - base); end
        vec++; if (data_b !== 32'h0 || ack_b !== 1'b0) begin err++; $display("FAIL single_b_untouched got %h/%b need 0/0", data_b, ack_b); end
        mem_fixed_en = 1'b0;
    endtask

    task automatic test_three();
        logic [2:0] seq [0:3];
        logic [2:0] prev;
        int         n;
        int         base;
        do_reset();
        mem_wait = 2;
        base = mreq_toggles;
        addr_a = 25'h0000100;
        addr_b = 25'h0000200;
        addr_c = 25'h0000300;
        req_a = 1'b1;
        req_b = 1'b1;
        req_c = 1'b1;
        n = 0;
        prev = 3'b000;
        for (int cyc = 0; cyc < 60 && {ack_c, ack_b, ack_a} !== 3'b111; cyc++) begin
            @(negedge clk_sys);
            if (grant != 3'b000 && prev == 3'b000 && n < 4) begin
                seq[n] = grant;
                n++;
            end
            prev = grant;
        end
        vec++; if (n != 3) begin err++; $display("FAIL three_count got %0d grants need 3", n); end
        else begin
            vec++; if (seq[0] !== 3'b001) begin err++; $display("FAIL three_g0 got %b need 001", seq[0]); end
            vec++; if (seq[1] !== 3'b010) begin err++; $display("FAIL three_g1 got %b need 010", seq[1]); end
            vec++; if (seq[2] !== 3'b100) begin err++; $display("FAIL three_g2 got %b need 100", seq[2]); end
        end
        vec++; if (mreq_toggles - base !== 3) begin err++; $display("FAIL three_toggles got %0d need 3", mreq_toggles - base); end
        vec++; if (data_a !== 32'hA000_0100) begin err++; $display("FAIL three_data_a got %h need a0000100", data_a); end
        vec++; if (data_b !== 32'hA000_0200) begin err++; $display("FAIL three_data_b got %h need a0000200", data_b); end
        vec++; if (data_c !== 32'hA000_0300) begin err++; $display("FAIL three_data_c got %h need a0000300", data_c); end
    endtask

    task automatic test_fairness();
        logic [2:0] seq [0:5];
        logic [2:0] prev;
        int         n;
        int         cyc;
        do_reset();
        mem_wait = 2;
        addr_a = 25'h00000A0;
        addr_b = 25'h00000B0;
        n = 0;
        prev = 3'b000;
        for (int k = 0; k < 200 && n < 6; k++) begin
            @(negedge clk_sys);
            if (req_a == ack_a) req_a = ~req_a;
            if (req_b == ack_b) req_b = ~req_b;
            if (grant != 3'b000 && prev == 3'b000) begin
                seq[n] = grant;
                n++;
            end
            prev = grant;
        end
        vec++; if (n != 6) begin err++; $display("FAIL fair_count got %0d grants need 6", n); end
        else begin
            for (int i = 0; i < 6; i++) begin
                vec++;
                if (seq[i] !== ((i % 2 == 0) ? 3'b001 : 3'b010)) begin
                    err++; $display("FAIL fair_g%0d got %b need %b", i, seq[i], (i % 2 == 0) ? 3'b001 : 3'b010);
                end
            end
        end
        cyc = 0;
        while ((req_a != ack_a || req_b != ack_b) && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        vec++; if (cyc >= 50) begin err++; $display("FAIL fair_drain got pending need drained"); end
    endtask

    task automatic test_reset_wait();
        int base;
        do_reset();
        mem_hold = 1'b1;
        addr_c = 25'h0000055;
        req_c  = 1'b1;
        repeat (3) @(negedge clk_sys);
        vec++; if (mem_req === mem_ack) begin err++; $display("FAIL rw_open got mem_req=%b mem_ack=%b need unequal", mem_req, mem_ack); end
        do_reset();
        vec++; if (mem_req !== mem_ack) begin err++; $display("FAIL rw_resync got mem_req=%b need %b", mem_req, mem_ack); end
        vec++; if (ack_c !== 1'b0 || data_c !== 32'h0) begin err++; $display("FAIL rw_abandon got %b/%h need 0/0", ack_c, data_c); end
        vec++; if (grant !== 3'b000) begin err++; $display("FAIL rw_grant got %b need 000", grant); end
        base = mreq_toggles;
        repeat (10) @(negedge clk_sys);
        vec++; if (mreq_toggles - base !== 0) begin err++; $display("FAIL rw_quiet got %0d toggles need 0", mreq_toggles - base); end
        mem_hold = 1'b0;
    endtask

    task automatic test_late();
        int cyc;
        do_reset();
        mem_wait = 4;
        addr_b = 25'h00002B0;
        req_b  = 1'b1;
        repeat (3) @(negedge clk_sys);
        addr_c = 25'h00003C0;
        req_c  = 1'b1;
        cyc = 0;
        while (ack_b !== 1'b1 && cyc < 20) begin
            @(negedge clk_sys);
            cyc++;
        end
        vec++; if (cyc != 3) begin err++; $display("FAIL late_b_done got %0d cycles need 3", cyc); end
        vec++; if (data_b !== 32'hA000_02B0) begin err++; $display("FAIL late_data_b got %h need a00002b0", data_b); end
        vec++; if (grant !== 3'b000) begin err++; $display("FAIL late_idle got %b need 000", grant); end
        @(negedge clk_sys);
        vec++; if (grant !== 3'b100) begin err++; $display("FAIL late_grant_c got %b need 100", grant); end
        cyc = 0;
        while (ack_c !== 1'b1 && cyc < 20) begin
            @(negedge clk_sys);
            cyc++;
        end
        vec++; if (data_c !== 32'hA000_03C0) begin err++; $display("FAIL late_data_c got %h need a00003c0", data_c); end
        vec++; if (data_b !== 32'hA000_02B0 || ack_b !== 1'b1) begin
            err++; $display("FAIL late_b_kept got %h/%b need a00002b0/1", data_b, ack_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] prev_ack;
        logic [2:0] chg;
        int         total;
        int         bad;
        int         last;
        int         cnt_a, cnt_b, cnt_c;
        int         cyc;
        do_reset();
        mem_wait = 2;
        addr_a = 25'h1000001;
        addr_b = 25'h0ABCDEF;
        addr_c = 25'h0123456;
        prev_ack = 3'b000;
        total = 0; bad = 0; last = 0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 4200 && total < 1000; k++) begin
            @(negedge clk_sys);
            chg = {ack_c, ack_b, ack_a} ^ prev_ack;
            if (chg != 3'b000) begin
                if ($countones(chg) != 1) bad++;
                if (total > 0 && k - last != 4) bad++;
                last  = k;
                total = total + $countones(chg);
                cnt_a = cnt_a + int'(chg[0]);
                cnt_b = cnt_b + int'(chg[1]);
                cnt_c = cnt_c + int'(chg[2]);
            end
            prev_ack = {ack_c, ack_b, ack_a};
            if (req_a == ack_a) req_a = ~req_a;
            if (req_b == ack_b) req_b = ~req_b;
            if (req_c == ack_c) req_c = ~req_c;
        end
        vec++; if (total != 1000) begin err++; $display("FAIL b2b_total got %0d need 1000", total); end
        vec++; if (bad != 0) begin err++; $display("FAIL b2b_spacing got %0d bad completions need 0", bad); end
        vec++; if (cnt_a != 334 || cnt_b != 333 || cnt_c != 333) begin
            err++; $display("FAIL b2b_share got %0d/%0d/%0d need 334/333/333", cnt_a, cnt_b, cnt_c);
        end
        cyc = 0;
        while ({req_c, req_b, req_a} != {ack_c, ack_b, ack_a} && cyc < 40) begin
            @(negedge clk_sys);
            cyc++;
        end
        vec++; if (cyc >= 40) begin err++; $display("FAIL b2b_drain got pending need drained"); end
        vec++; if (data_a !== 32'hA100_0001 || data_b !== 32'hA0AB_CDEF || data_c !== 32'hA012_3456) begin
            err++; $display("FAIL b2b_data got %h %h %h need a1000001 a0abcdef a0123456", data_a, data_b, data_c);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_fairness();
        test_reset_wait();
        test_late();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
